// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline register: DEPTH-entry in-order buffer with valid/ready on
// both sides and a synchronous flush for branch/jump recovery.
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;

  logic push;
  logic pop;

  // Handshake outputs come only from registered occupancy, so a stall never
  // propagates combinationally from one stage to the next.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rp_q];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = in_data;
        wp_d        = (wp_q == LAST_IDX) ? '0 : wp_q + PTR_ONE;
      end
      if (pop) begin
        rp_d = (rp_q == LAST_IDX) ? '0 : rp_q + PTR_ONE;
      end
      // Simultaneous push and pop leave occupancy unchanged.
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: DEPTH=2 skid buffer, DEPTH=3 wrap
// behaviour and DEPTH=1 latch mode, each on its own instance.
module tb_pipe_stage_buffer;

  logic clk;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, iv2, or2, fl2, ir2, ov2;
  logic [31:0] d2, od2;
  logic [1:0]  cnt2;

  logic        rst3, iv3, or3, fl3, ir3, ov3;
  logic [31:0] d3, od3;
  logic [1:0]  cnt3;

  logic        rst1, iv1, or1, fl1, ir1, ov1;
  logic [31:0] d1, od1;
  logic [0:0]  cnt1;

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .CLK(clk), .RST(rst2), .in_valid(iv2), .in_ready(ir2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2), .count(cnt2)
  );

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .CLK(clk), .RST(rst3), .in_valid(iv3), .in_ready(ir3), .in_data(d3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .flush(fl3), .count(cnt3)
  );

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .CLK(clk), .RST(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1), .count(cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst3 = 1'b1; rst1 = 1'b1;
    iv2 = 0; or2 = 0; fl2 = 0; d2 = '0;
    iv3 = 0; or3 = 0; fl3 = 0; d3 = '0;
    iv1 = 0; or1 = 0; fl1 = 0; d1 = '0;
    #2;
    checks++; if (ir2 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", ir2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", ov2); end
    checks++; if (od2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", od2); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", cnt2); end
    checks++; if (cnt3 !== 2'd0 || ov3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_d3: got count %0d valid %b expected 0 0", cnt3, ov3); end
    checks++; if (cnt1 !== 1'd0 || ir1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_d1: got count %0d ready %b expected 0 1", cnt1, ir1); end
    @(posedge clk);
    #2;
    rst2 = 1'b0; rst3 = 1'b0; rst1 = 1'b0;
  endtask

  task automatic test_fill();
    or2 = 0; iv2 = 1; d2 = 32'hAAAA0001;
    step();
    checks++; if (cnt2 !== 2'd1) begin errors++; $display("[TB] FAIL fill_count1: got %0d expected 1", cnt2); end
    checks++; if (od2 !== 32'hAAAA0001 || ov2 !== 1'b1) begin errors++; $display("[TB] FAIL fill_head1: got %h valid %b expected aaaa0001 1", od2, ov2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready1: got %b expected 1", ir2); end
    d2 = 32'hAAAA0002;
    step();
    checks++; if (cnt2 !== 2'd2) begin errors++; $display("[TB] FAIL fill_count2: got %0d expected 2", cnt2); end
    checks++; if (ir2 !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_ready: got %b expected 0", ir2); end
    checks++; if (od2 !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL fill_head2: got %h expected aaaa0001", od2); end
    d2 = 32'hAAAA0003;
    step();
    checks++; if (cnt2 !== 2'd2 || od2 !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL fill_hold: got count %0d head %h expected 2 aaaa0001", cnt2, od2); end
    or2 = 1;
    step();
    checks++; if (cnt2 !== 2'd1 || od2 !== 32'hAAAA0002) begin errors++; $display("[TB] FAIL fill_pop1: got count %0d head %h expected 1 aaaa0002", cnt2, od2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("[TB] FAIL fill_recover_ready: got %b expected 1", ir2); end
    step();
    checks++; if (cnt2 !== 2'd1 || od2 !== 32'hAAAA0003) begin errors++; $display("[TB] FAIL fill_pop2: got count %0d head %h expected 1 aaaa0003", cnt2, od2); end
    iv2 = 0;
    step();
    checks++; if (cnt2 !== 2'd0 || ov2 !== 1'b0) begin errors++; $display("[TB] FAIL fill_drain: got count %0d valid %b expected 0 0", cnt2, ov2); end
    or2 = 0;
  endtask

  task automatic test_streaming();
    iv2 = 1; or2 = 1; d2 = 32'd0;
    step();
    checks++; if (od2 !== 32'd0 || cnt2 !== 2'd1) begin errors++; $display("[TB] FAIL stream_first: got data %0d count %0d expected 0 1", od2, cnt2); end
    for (int i = 1; i < 10; i++) begin
      d2 = i;
      step();
      checks++;
      if (od2 !== 32'(i) || cnt2 !== 2'd1 || ov2 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_item: got data %0d count %0d valid %b expected %0d 1 1", od2, cnt2, ov2, i);
      end
    end
    iv2 = 0;
    step();
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL stream_drain: got count %0d expected 0", cnt2); end
    or2 = 0;
  endtask

  task automatic test_wrap();
    logic [14:0] iv_pat;
    logic [14:0] or_pat;
    int pushed;
    int popped;
    int mcount;
    logic do_push;
    logic do_pop;
    iv_pat = 15'b000001111101111;
    or_pat = 15'b111111100111000;
    pushed = 0;
    popped = 0;
    mcount = 0;
    for (int c = 0; c < 15; c++) begin
      iv3 = iv_pat[c] && (pushed < 7);
      or3 = or_pat[c];
      d3  = 32'h10 + pushed;
      do_push = iv3 && (mcount != 3);
      do_pop  = or3 && (mcount != 0);
      if (do_pop) begin
        checks++;
        if (od3 !== 32'h10 + popped) begin
          errors++;
          $display("[TB] FAIL wrap_order: got %h expected %h", od3, 32'h10 + popped);
        end
        popped++;
      end
      if (do_push) pushed++;
      mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      step();
      checks++;
      if (cnt3 !== 2'(mcount) || cnt3 > 2'd3) begin
        errors++;
        $display("[TB] FAIL wrap_count: got %0d expected %0d", cnt3, mcount);
      end
    end
    checks++;
    if (pushed != 7 || popped != 7) begin
      errors++;
      $display("[TB] FAIL wrap_totals: got pushed %0d popped %0d expected 7 7", pushed, popped);
    end
    iv3 = 0; or3 = 0;
  endtask

  task automatic test_flush();
    or2 = 0; iv2 = 1; d2 = 32'hB1;
    step();
    d2 = 32'hB2;
    step();
    checks++; if (cnt2 !== 2'd2) begin errors++; $display("[TB] FAIL flush_prefill: got %0d expected 2", cnt2); end
    fl2 = 1; d2 = 32'hDEAD;
    step();
    fl2 = 0; iv2 = 0;
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", cnt2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", ov2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 1", ir2); end
    step();
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL flush_stays_empty: got %0d expected 0", cnt2); end
    iv2 = 1; d2 = 32'hC1;
    step();
    iv2 = 0;
    checks++; if (od2 !== 32'hC1 || cnt2 !== 2'd1) begin errors++; $display("[TB] FAIL flush_next_item: got %h count %0d expected c1 1", od2, cnt2); end
    or2 = 1;
    step();
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL flush_final_drain: got %0d expected 0", cnt2); end
    or2 = 0;
  endtask

  task automatic test_latch_mode();
    int emerged;
    int accepted;
    emerged = 0;
    accepted = 0;
    iv1 = 1; or1 = 1;
    for (int c = 0; c < 10; c++) begin
      d1 = 32'h50 + accepted;
      checks++;
      if (ir1 !== ((c % 2 == 0) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL latch_ready: cycle %0d got %b expected %b", c, ir1, (c % 2 == 0));
      end
      if (ov1 === 1'b1) begin
        checks++;
        if (od1 !== 32'h50 + emerged) begin
          errors++;
          $display("[TB] FAIL latch_data: got %h expected %h", od1, 32'h50 + emerged);
        end
        emerged++;
      end
      if (ir1 === 1'b1) accepted++;
      step();
    end
    checks++;
    if (emerged != 5) begin errors++; $display("[TB] FAIL latch_total: got %0d expected 5", emerged); end
    iv1 = 0; or1 = 0;
  endtask

  task automatic test_async_reset();
    or2 = 0; iv2 = 1; d2 = 32'hE1;
    step();
    d2 = 32'hE2;
    step();
    iv2 = 0;
    checks++; if (cnt2 !== 2'd2) begin errors++; $display("[TB] FAIL areset_prefill: got %0d expected 2", cnt2); end
    #3;
    rst2 = 1'b1;
    #1;
    checks++; if (ov2 !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", ov2); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", cnt2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready: got %b expected 1", ir2); end
    checks++; if (od2 !== 32'h0) begin errors++; $display("[TB] FAIL areset_data: got %h expected 0", od2); end
    #1;
    rst2 = 1'b0;
    iv2 = 1; d2 = 32'hF1;
    step();
    iv2 = 0;
    checks++; if (cnt2 !== 2'd1 || od2 !== 32'hF1) begin errors++; $display("[TB] FAIL areset_first_push: got count %0d head %h expected 1 f1", cnt2, od2); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill();
    test_streaming();
    test_wrap();
    test_flush();
    test_latch_mode();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
